// File: rtl/clk_div_if.sv
// Request/status bundle between the register file (master) and the divider
// sequencing controller (slave); everything lives in the ref-clock domain.
interface clk_div_if;
    logic       i_enable;
    logic       i_req_valid;
    logic [7:0] i_req_ratio;
    logic       o_req_ready;
    logic       o_clk_en;
    logic [7:0] o_div_ratio;
    logic       o_locked;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_enable,
        output i_req_valid,
        output i_req_ratio,
        input  o_req_ready,
        input  o_clk_en,
        input  o_div_ratio,
        input  o_locked,
        input  o_busy,
        input  o_done,
        input  o_err
    );

    modport slave (
        input  i_enable,
        input  i_req_valid,
        input  i_req_ratio,
        output o_req_ready,
        output o_clk_en,
        output o_div_ratio,
        output o_locked,
        output o_busy,
        output o_done,
        output o_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-safe enable/ratio sequencer for the ref-clock divider.
// Optional build macro CLK_DIV_CTRL_RATIO_CHECK_EN rejects ratio codes outside {1,4,8,16,32}.
module clk_div_ctrl #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned LOCK_CYC    = 64,
    parameter logic [7:0]  RESET_RATIO = 8'd32
) (
    input logic     i_ref_clk,
    input logic     i_rst_n,
    clk_div_if.slave bus
);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_LOCK  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    localparam int unsigned CNT_MAX = (SETTLE_CYC > LOCK_CYC) ? SETTLE_CYC : LOCK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYC - 1);

`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
    function automatic logic ratio_ok(input logic [7:0] r);
        return (r == 8'd1) || (r == 8'd4) || (r == 8'd8) ||
               (r == 8'd16) || (r == 8'd32);
    endfunction
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             clk_en_q;
    logic [7:0]       ratio_q;
    logic [7:0]       pend_ratio;
    logic             pend;
    logic             locked_q;
    logic             done_q;
    logic             err_q;

    logic             ready;
    logic             accept;
    logic             legal;
    logic             commit_ok;
    logic             commit_err;

    assign ready  = (state == S_OFF) || (state == S_RUN);
    assign accept = bus.i_req_valid && ready;

`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
    assign legal = ratio_ok(bus.i_req_ratio);
`else
    assign legal = 1'b1;
`endif

    assign commit_ok  = accept && legal;
    assign commit_err = accept && !legal;

    // Saturating increment so a mis-set terminal count can never wrap the counter.
    assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_OFF;
            cnt      <= '0;
            clk_en_q <= 1'b0;
            ratio_q  <= RESET_RATIO;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pend     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                S_OFF: begin
                    // Divider is stopped, so a new ratio can be written straight through.
                    if (commit_ok) begin
                        ratio_q <= bus.i_req_ratio;
                        done_q  <= 1'b1;
                    end
                    if (commit_err) begin
                        err_q <= 1'b1;
                    end
                    if (bus.i_enable) begin
                        state    <= S_LOCK;
                        clk_en_q <= 1'b1;
                        cnt      <= '0;
                    end
                end

                S_RUN: begin
                    if (!bus.i_enable) begin
                        state    <= S_OFF;
                        clk_en_q <= 1'b0;
                        locked_q <= 1'b0;
                        if (commit_ok) begin
                            ratio_q <= bus.i_req_ratio;
                            done_q  <= 1'b1;
                        end
                        if (commit_err) begin
                            err_q <= 1'b1;
                        end
                    end else if (commit_err) begin
                        err_q <= 1'b1;
                    end else if (commit_ok) begin
                        if (bus.i_req_ratio == ratio_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state    <= S_DRAIN;
                            clk_en_q <= 1'b0;
                            locked_q <= 1'b0;
                            cnt      <= '0;
                            pend     <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (!bus.i_enable) begin
                        // Abort: divider is already stopped, so the latched ratio is safe to commit.
                        state    <= S_OFF;
                        clk_en_q <= 1'b0;
                        locked_q <= 1'b0;
                        ratio_q  <= pend_ratio;
                        done_q   <= pend;
                        pend     <= 1'b0;
                    end else if (cnt == SETTLE_LAST) begin
                        state   <= S_LOAD;
                        ratio_q <= pend_ratio;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_LOAD: begin
                    if (!bus.i_enable) begin
                        state    <= S_OFF;
                        clk_en_q <= 1'b0;
                        locked_q <= 1'b0;
                        done_q   <= pend;
                        pend     <= 1'b0;
                    end else begin
                        state    <= S_LOCK;
                        clk_en_q <= 1'b1;
                        cnt      <= '0;
                    end
                end

                S_LOCK: begin
                    if (!bus.i_enable) begin
                        state    <= S_OFF;
                        clk_en_q <= 1'b0;
                        locked_q <= 1'b0;
                        done_q   <= pend;
                        pend     <= 1'b0;
                    end else if (cnt == LOCK_LAST) begin
                        state    <= S_RUN;
                        locked_q <= 1'b1;
                        done_q   <= pend;
                        pend     <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state    <= S_OFF;
                    clk_en_q <= 1'b0;
                    locked_q <= 1'b0;
                    cnt      <= '0;
                    pend     <= 1'b0;
                end
            endcase
        end
    end

    // Pending ratio is plain data: only meaningful while a change is in flight.
    always_ff @(posedge i_ref_clk) begin
        if ((state == S_RUN) && bus.i_enable && commit_ok) begin
            pend_ratio <= bus.i_req_ratio;
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_busy      = (state == S_DRAIN) || (state == S_LOAD) || (state == S_LOCK);
    assign bus.o_clk_en    = clk_en_q;
    assign bus.o_div_ratio = ratio_q;
    assign bus.o_locked    = locked_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed-vector bench for clk_div_ctrl at default parameters.
module tb_clk_div_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    clk_div_if bus();

    clk_div_ctrl dut (
        .i_ref_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full change sequence from RUN; i counts edges after the handshake edge E0.
    task automatic run_change(input logic [7:0] old_r, input logic [7:0] new_r);
        bus.i_req_valid = 1'b1;
        bus.i_req_ratio = new_r;
        for (int i = 0; i <= 70; i++) begin
            step();
            if (i == 0) bus.i_req_valid = 1'b0;
            chk("chg_clk_en", bus.o_clk_en,    (i >= 5) ? 1 : 0);
            chk("chg_ratio",  bus.o_div_ratio, (i >= 4) ? new_r : old_r);
            chk("chg_locked", bus.o_locked,    (i >= 69) ? 1 : 0);
            chk("chg_done",   bus.o_done,      (i == 69) ? 1 : 0);
            chk("chg_ready",  bus.o_req_ready, (i >= 69) ? 1 : 0);
        end
    endtask

    initial begin
        n_chk           = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        bus.i_enable    = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_req_ratio = 8'd0;

        step();
        step();
        chk("rst_clk_en", bus.o_clk_en,    0);
        chk("rst_ratio",  bus.o_div_ratio, 32);
        chk("rst_locked", bus.o_locked,    0);
        chk("rst_done",   bus.o_done,      0);
        chk("rst_err",    bus.o_err,       0);
        chk("rst_ready",  bus.o_req_ready, 1);
        chk("rst_busy",   bus.o_busy,      0);
        rst_n = 1'b1;
        step();

        // Enable from OFF: clk_en right after E0, locked after E64.
        bus.i_enable = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            step();
            chk("en_clk_en", bus.o_clk_en,    1);
            chk("en_ratio",  bus.o_div_ratio, 32);
            chk("en_locked", bus.o_locked,    (i >= 64) ? 1 : 0);
            chk("en_busy",   bus.o_busy,      (i < 64) ? 1 : 0);
            chk("en_done",   bus.o_done,      0);
        end

        run_change(8'd32, 8'd8);

        // Equal ratio: done only, clock never drops.
        bus.i_req_valid = 1'b1;
        bus.i_req_ratio = 8'd8;
        step();
        bus.i_req_valid = 1'b0;
        chk("eq_done",   bus.o_done,   1);
        chk("eq_clk_en", bus.o_clk_en, 1);
        chk("eq_locked", bus.o_locked, 1);
        chk("eq_busy",   bus.o_busy,   0);
        step();
        chk("eq_done_end", bus.o_done,   0);
        chk("eq_clk_en2",  bus.o_clk_en, 1);
        chk("eq_locked2",  bus.o_locked, 1);

`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
        bus.i_req_valid = 1'b1;
        bus.i_req_ratio = 8'd5;
        step();
        bus.i_req_valid = 1'b0;
        chk("ill_err",    bus.o_err,       1);
        chk("ill_done",   bus.o_done,      0);
        chk("ill_ratio",  bus.o_div_ratio, 8);
        chk("ill_clk_en", bus.o_clk_en,    1);
        step();
        chk("ill_err_end", bus.o_err,       0);
        chk("ill_ratio2",  bus.o_div_ratio, 8);
`else
        run_change(8'd8, 8'd5);
        chk("ill_err_tied", bus.o_err, 0);
`endif

        // Abort two edges into DRAIN of a change to 16.
        bus.i_req_valid = 1'b1;
        bus.i_req_ratio = 8'd16;
        step();
        bus.i_req_valid = 1'b0;
        chk("ab_busy", bus.o_busy, 1);
        step();
        bus.i_enable = 1'b0;
        step();
        chk("ab_clk_en", bus.o_clk_en,    0);
        chk("ab_locked", bus.o_locked,    0);
        chk("ab_ratio",  bus.o_div_ratio, 16);
        chk("ab_done",   bus.o_done,      1);
        chk("ab_busy2",  bus.o_busy,      0);
        chk("ab_ready",  bus.o_req_ready, 1);
        step();
        chk("ab_done_end", bus.o_done, 0);

        // OFF request without enable.
        bus.i_req_valid = 1'b1;
        bus.i_req_ratio = 8'd4;
        step();
        bus.i_req_valid = 1'b0;
        chk("off_ratio",  bus.o_div_ratio, 4);
        chk("off_done",   bus.o_done,      1);
        chk("off_clk_en", bus.o_clk_en,    0);
        chk("off_ready",  bus.o_req_ready, 1);

        // OFF request together with enable: commit, done, and straight into LOCK.
        bus.i_req_valid = 1'b1;
        bus.i_req_ratio = 8'd1;
        bus.i_enable    = 1'b1;
        step();
        chk("offen_ratio",  bus.o_div_ratio, 1);
        chk("offen_done",   bus.o_done,      1);
        chk("offen_clk_en", bus.o_clk_en,    1);
        chk("offen_busy",   bus.o_busy,      1);
        chk("offen_locked", bus.o_locked,    0);

        // Request held while not ready stalls without effect.
        bus.i_req_ratio = 8'd16;
        step();
        step();
        step();
        chk("stall_ready", bus.o_req_ready, 0);
        chk("stall_ratio", bus.o_div_ratio, 1);
        chk("stall_done",  bus.o_done,      0);

        // Asynchronous reset in the middle of LOCK.
        #3;
        rst_n           = 1'b0;
        bus.i_req_valid = 1'b0;
        #1;
        chk("arst_clk_en", bus.o_clk_en,    0);
        chk("arst_ratio",  bus.o_div_ratio, 32);
        chk("arst_locked", bus.o_locked,    0);
        chk("arst_busy",   bus.o_busy,      0);
        chk("arst_ready",  bus.o_req_ready, 1);
        chk("arst_done",   bus.o_done,      0);
        step();
        chk("arst_hold_clk_en", bus.o_clk_en, 0);
        chk("arst_hold_busy",   bus.o_busy,   0);

        rst_n        = 1'b1;
        bus.i_enable = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
